fifo_axi_beat_reader: RTL
=========================

Name: fifo_axi_beat_reader

Overview:
- Read-side companion to the crossbar's sync FIFO: drains buffered data beats from a push/pull FIFO and presents them as an AXI-style valid/ready beat stream with id and last.
- A burst command (len, id) is accepted first. Exactly len+1 beats are then pulled from the FIFO and forwarded. last is asserted on the final beat.
- A registered 2-entry output buffer breaks every combinational path from m_ready to fifo_pull.

Parameters:
- DATA_WIDTH, 16, beat payload width; must match the attached FIFO.
- ID_WIDTH, 4, transaction id width.
- LEN_WIDTH, 8, burst length field width; AXI encoding, beats = len+1.

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- srst  in  1  synchronous clear, active-high; same effect as reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  burst command accepted when cmd_valid is also high.
- cmd_len  in  LEN_WIDTH  beats minus one.
- cmd_id  in  ID_WIDTH  id attached to every beat of the burst.
- fifo_empty  in  1  FIFO has no data.
- fifo_data  in  DATA_WIDTH  FIFO head word; valid in the same cycle whenever !fifo_empty.
- fifo_pull  out  1  pop FIFO head this cycle.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts beat.
- m_data  out  DATA_WIDTH  beat payload.
- m_id  out  ID_WIDTH  beat id.
- m_last  out  1  final beat of burst.

Behaviour:
- Reset (aresetn low at a clock edge, or srst high):
  - state becomes IDLE; beat counter is 0; output buffer occupancy is 0.
  - m_valid=0; m_data, m_id, m_last are 0.
  - fifo_pull=0 and cmd handshakes are ignored in that cycle.
  - Reset mid-burst discards all remaining beats. No partial drain.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch len and id, clear counter, go to BURST.
  - BURST: cmd_ready=0.
- fifo_pull = (state==BURST) && !fifo_empty && (occ<2), where occ is the registered buffer occupancy. fifo_pull never depends on m_ready.
- Each pulled word is written to the output buffer as {fifo_data, id, last=(cnt==len)}. The counter then increments.
- A pull with cnt==len returns the block to IDLE on the next edge.
  - Exactly one idle cycle separates the last pull of a burst from the next command acceptance.
- len=0 is a single-beat burst: m_last=1 on that beat. len at maximum (255 with LEN_WIDTH=8) is 256 beats; the counter must not wrap before last.
- Output buffer:
  - 2-entry FIFO. m_valid = (occ!=0). m_data, m_id, m_last come from the head entry.
  - A beat transfers on m_valid&&m_ready.
  - Simultaneous write and read keeps occ unchanged.
  - Once m_valid is high, head contents hold stable until accepted (AXI rule).
- Throughput and latency:
  - With m_ready held high and FIFO non-empty: one beat per cycle, steady-state occ=1.
  - Latency from pull to m_valid is 1 cycle.
- Backpressure: m_ready low lets occ reach 2, then fifo_pull drops to 0 until a beat drains.
- FIFO empty mid-burst: pulls stall and the counter holds. The burst resumes when data arrives; no beat is skipped or duplicated.
- A command arriving while in BURST waits with cmd_ready=0. The command must stay stable.

Decomposition:
- Shared package (crossbar pkg):
  - state enum {IDLE, BURST}.
  - packed struct beat_t {data, id, last}, parameterised by the pkg widths.
- Sub-module beat_skid_buf: 2-entry registered buffer of beat_t with wr/rd/occ, same reset rules.
- FSM and counter stay in the top module.

Test Plan:
- Reset mid-burst: cmd len=3 id=5, 2 beats out, aresetn low 1 cycle -> m_valid=0, occ=0, cmd_ready=1 next cycle; the 2 leftover FIFO words are not pulled.
- Single beat: cmd len=0 id=2, FIFO holds 0xABCD -> exactly one beat, data=0xABCD, id=2, m_last=1; then IDLE.
- Streaming: cmd len=7 id=1, FIFO prefilled 8 words 0..7, m_ready=1 -> 8 consecutive beats in 8 cycles, data 0..7, m_last only on data=7.
- Backpressure: cmd len=3, m_ready=0 for 5 cycles -> exactly 2 pulls, then fifo_pull=0; m_data stable; release m_ready -> remaining beats in order, last on 4th.
- FIFO underrun: cmd len=3, FIFO supplies 1 word, empty 4 cycles, then 3 words -> 4 beats total, counter held during gap, m_last on 4th.
- Back-to-back commands: cmd A len=1 id=3 then cmd B len=2 id=4 held valid -> B accepted exactly 1 cycle after A's last pull; 5 beats with ids 3,3,4,4,4; m_last on beats 2 and 5.

Source files
------------

// File: rtl/fifo_axi_beat_reader_pkg.sv
// Shared types for the crossbar beat reader: FSM state, beat record and buffer sizing.
// Widths here define the beat_t layout used by the top and the output buffer.
package fifo_axi_beat_reader_pkg;

    localparam int DATA_W    = 16;
    localparam int ID_W      = 4;
    localparam int LEN_W     = 8;
    localparam int BUF_DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_axi_beat_reader_if.sv
// Command, FIFO-side and beat-stream signals of the beat reader.
// master = the reader itself, slave = the surrounding crossbar / testbench.
interface fifo_axi_beat_reader_if
    import fifo_axi_beat_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ID_WIDTH   = ID_W,
    parameter int LEN_WIDTH  = LEN_W
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [ID_WIDTH-1:0]   cmd_id;

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pull;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ID_WIDTH-1:0]   m_id;
    logic                  m_last;

    modport master (
        input  cmd_valid, cmd_len, cmd_id, fifo_empty, fifo_data, m_ready,
        output cmd_ready, fifo_pull, m_valid, m_data, m_id, m_last
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_id, fifo_empty, fifo_data, m_ready,
        input  cmd_ready, fifo_pull, m_valid, m_data, m_id, m_last
    );

endinterface

// File: rtl/fifo_axi_beat_reader_skid.sv
// Two-entry registered beat buffer between the FIFO pull side and the AXI-style output.
// Head contents only change on a read, so a presented beat stays stable until taken.
module beat_skid_buf
    import fifo_axi_beat_reader_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_i,
    input  beat_t wr_beat_i,
    input  logic  rd_i,
    output beat_t rd_beat_o,
    output occ_t  occ_o
);

    beat_t mem_q [BUF_DEPTH];
    logic  wr_ptr_q, wr_ptr_d;
    logic  rd_ptr_q, rd_ptr_d;
    occ_t  occ_q, occ_d;
    logic  wr_en, rd_en;

    assign wr_en = wr_i && (occ_q != 2'd2);
    assign rd_en = rd_i && (occ_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_beat_i;
            end
        end
    end

    // An empty buffer presents an all-zero beat rather than stale contents.
    assign rd_beat_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_axi_beat_reader.sv
// Drains a sync FIFO into an id/last tagged valid/ready beat stream, one burst command at a time.
// fifo_pull looks only at registered buffer occupancy, never at m_ready.
module fifo_axi_beat_reader
    import fifo_axi_beat_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ID_WIDTH   = ID_W,
    parameter int LEN_WIDTH  = LEN_W
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   srst,
    fifo_axi_beat_reader_if.master bus
);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] pull_data;

    logic  rst;
    logic  cmd_ready;
    logic  cmd_fire;
    logic  pull;
    logic  last_pull;
    occ_t  occ;
    beat_t wr_beat;
    beat_t head_beat;

    assign rst       = !aresetn || srst;
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign last_pull = (cnt_q == len_q);
    assign pull_data = bus.fifo_data;

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire)          state_d = BURST;
            BURST:   if (pull && last_pull) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Reset gates both handshakes so nothing is consumed in the clearing cycle.
    always_comb begin
        cmd_ready = 1'b0;
        pull      = 1'b0;
        case (state_q)
            IDLE:    cmd_ready = !rst;
            BURST:   pull      = !rst && !bus.fifo_empty && (occ != 2'd2);
            default: ;
        endcase
    end

    always_comb begin
        len_d = len_q;
        id_d  = id_q;
        cnt_d = cnt_q;
        if (cmd_fire) begin
            len_d = bus.cmd_len;
            id_d  = bus.cmd_id;
            cnt_d = '0;
        end else if (pull) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            len_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
        end
    end

    assign wr_beat = '{data: pull_data, id: id_q, last: last_pull};

    beat_skid_buf u_buf (
        .clk       (aclk),
        .rst       (rst),
        .wr_i      (pull),
        .wr_beat_i (wr_beat),
        .rd_i      (bus.m_ready),
        .rd_beat_o (head_beat),
        .occ_o     (occ)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.fifo_pull = pull;
    assign bus.m_valid   = (occ != 2'd0);
    assign bus.m_data    = head_beat.data;
    assign bus.m_id      = head_beat.id;
    assign bus.m_last    = head_beat.last;

endmodule
